// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: ROM address/data, redirect request and the decode handshake.
interface instr_fetch_ctrl_if;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  // Fetch controller side
  modport master (
    input  fetch_en, imem_rd, redirect_en, redirect_pc, out_ready,
    output imem_addr, out_valid, out_instr, out_pc
  );

  // Environment side: PC logic, ROM and decode
  modport slave (
    output fetch_en, imem_rd, redirect_en, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer with a small prefetch queue. Owns the fetch PC, captures
// each ROM word with its PC, and hands the queue head to decode.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  instr_fetch_ctrl_if.master bus
);

  localparam int unsigned    PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];

  logic empty;
  logic valid;
  logic pop;
  logic push;

  // Handshake and push decisions; a full queue may still push when it pops
  always_comb begin
    empty = (count_q == '0);
    valid = ~empty & ~bus.redirect_en;
    pop   = valid & bus.out_ready;
    push  = bus.fetch_en & ~bus.redirect_en & ((count_q < DEPTH_C) | pop);
  end

  // Next-state for fetch PC, pointers and occupancy
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (bus.redirect_en) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage; contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= bus.imem_rd;
    end
  end

  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = valid;
  assign bus.out_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];
  assign bus.out_instr = empty ? '0 : instr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table with fixed expectations,
// a queue-based scoreboard running on every cycle, and a random phase.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] B   = 32'hBFC00000;
  localparam logic [31:0] KEY = 32'h5A5A5A5A;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_ctrl_if bus ();

  // Combinational ROM model
  assign bus.imem_rd = bus.imem_addr ^ KEY;

  instr_fetch_ctrl #(.RESET_PC(B), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          r;
    bit          fe;
    bit          re;
    logic [31:0] rpc;
    bit          rdy;
    bit          chk;
    bit          exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vec [$];

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Scoreboard: expected PCs of queued entries, plus the model fetch PC
  logic [31:0] sb_q [$];
  logic [31:0] m_fpc;
  bit          m_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input bit r, input bit fe, input bit re, input logic [31:0] rpc,
                     input bit rdy, input bit chk, input bit v,
                     input logic [31:0] pc, input logic [31:0] addr);
    vec_t t;
    t.r = r; t.fe = fe; t.re = re; t.rpc = rpc; t.rdy = rdy;
    t.chk = chk; t.exp_v = v; t.exp_pc = pc; t.exp_addr = addr;
    vec.push_back(t);
  endtask

  // One clock cycle: drive, compare (table and scoreboard), advance the model
  task automatic cycle(input vec_t t);
    bit mv, mpop, mpush;
    rst             = t.r;
    bus.fetch_en    = t.fe;
    bus.redirect_en = t.re;
    bus.redirect_pc = t.rpc;
    bus.out_ready   = t.rdy;
    #1;
    if (t.chk) begin
      check("tbl_valid", {31'd0, bus.out_valid}, {31'd0, t.exp_v});
      check("tbl_addr", bus.imem_addr, t.exp_addr);
      if (t.exp_v) begin
        check("tbl_pc", bus.out_pc, t.exp_pc);
        check("tbl_instr", bus.out_instr, t.exp_pc ^ KEY);
      end
    end
    if (m_ok) begin
      mv = (sb_q.size() != 0) && !t.re;
      check("sb_valid", {31'd0, bus.out_valid}, {31'd0, mv});
      check("sb_addr", bus.imem_addr, m_fpc);
      if (sb_q.size() != 0) begin
        check("sb_pc", bus.out_pc, sb_q[0]);
        check("sb_instr", bus.out_instr, sb_q[0] ^ KEY);
      end else begin
        check("sb_pc_empty", bus.out_pc, 32'd0);
        check("sb_instr_empty", bus.out_instr, 32'd0);
      end
    end
    mv    = (sb_q.size() != 0) && !t.re;
    mpop  = mv && t.rdy;
    mpush = t.fe && !t.re && ((sb_q.size() < 4) || mpop);
    if (t.r) begin
      sb_q.delete();
      m_fpc = B;
      m_ok  = 1'b1;
    end else if (t.re) begin
      sb_q.delete();
      m_fpc = {t.rpc[31:2], 2'b00};
    end else begin
      if (mpop) void'(sb_q.pop_front());
      if (mpush) begin
        sb_q.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t;
    rst = 1'b1;
    bus.fetch_en = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;

    // Reset then run
    add(1,0,0,0,0, 0,0,0,0);
    add(1,0,0,0,0, 1,0,0,B);
    add(0,1,0,0,1, 1,0,0,B);
    add(0,1,0,0,1, 1,1,B,B+4);
    add(0,1,0,0,1, 1,1,B+4,B+8);
    add(0,1,0,0,1, 1,1,B+8,B+32'hC);
    // Redirect during reset, then fill and stall for 8 cycles
    add(1,0,1,B+32'h200,0, 1,0,0,B+32'h10);
    add(1,0,1,B+32'h200,0, 1,0,0,B);
    add(0,1,0,0,0, 1,0,0,B);
    add(0,1,0,0,0, 1,1,B,B+4);
    add(0,1,0,0,0, 1,1,B,B+8);
    add(0,1,0,0,0, 1,1,B,B+32'hC);
    for (int i = 0; i < 4; i++) add(0,1,0,0,0, 1,1,B,B+32'h10);
    // Single push+pop at full, then stall, then drain
    add(0,1,0,0,1, 1,1,B,B+32'h10);
    add(0,1,0,0,0, 1,1,B+4,B+32'h14);
    add(0,1,0,0,1, 1,1,B+4,B+32'h14);
    add(0,1,0,0,1, 1,1,B+8,B+32'h18);
    add(0,1,0,0,1, 1,1,B+32'hC,B+32'h1C);
    add(0,1,0,0,1, 1,1,B+32'h10,B+32'h20);
    add(0,0,0,0,1, 1,1,B+32'h14,B+32'h24);
    // Redirect with three queued entries
    add(0,1,1,B+32'h103,1, 1,0,0,B+32'h24);
    add(0,1,0,0,1, 1,0,0,B+32'h100);
    add(0,1,0,0,1, 1,1,B+32'h100,B+32'h104);
    add(0,1,0,0,1, 1,1,B+32'h104,B+32'h108);
    // fetch_en low for 5 cycles, then re-enable
    add(0,0,0,0,1, 1,1,B+32'h108,B+32'h10C);
    for (int i = 0; i < 4; i++) add(0,0,0,0,1, 1,0,0,B+32'h10C);
    add(0,1,0,0,1, 1,0,0,B+32'h10C);
    add(0,1,0,0,1, 1,1,B+32'h10C,B+32'h110);
    add(0,1,0,0,1, 1,1,B+32'h110,B+32'h114);
    // Back-to-back redirects: last one wins
    add(0,1,1,B+32'h300,1, 1,0,0,B+32'h118);
    add(0,1,1,B+32'h404,1, 1,0,0,B+32'h300);
    add(0,1,0,0,1, 1,0,0,B+32'h404);
    add(0,1,0,0,1, 1,1,B+32'h404,B+32'h408);
    // Fetch PC wraps modulo 2^32
    add(0,1,1,32'hFFFFFFFB,1, 1,0,0,B+32'h40C);
    add(0,1,0,0,1, 1,0,0,32'hFFFFFFF8);
    add(0,1,0,0,1, 1,1,32'hFFFFFFF8,32'hFFFFFFFC);
    add(0,1,0,0,1, 1,1,32'hFFFFFFFC,32'h0);
    add(0,1,0,0,1, 1,1,32'h0,32'h4);

    foreach (vec[i]) cycle(vec[i]);

    // Random traffic checked only by the scoreboard
    for (int i = 0; i < 400; i++) begin
      t.r     = ($urandom_range(0, 99) < 2);
      t.fe    = ($urandom_range(0, 99) < 80);
      t.re    = ($urandom_range(0, 99) < 5);
      t.rpc   = B + ($urandom & 32'h0000_0FFF);
      t.rdy   = ($urandom_range(0, 99) < 60);
      t.chk   = 1'b0;
      t.exp_v = 1'b0; t.exp_pc = '0; t.exp_addr = '0;
      cycle(t);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
